// File: rtl/tpu_seq_pkg.sv
// Shared definitions for the tpu_seq instruction sequencer: opcodes, FSM states, field offsets.
package tpu_seq_pkg;

   localparam logic [3:0] OpNop  = 4'h0;
   localparam logic [3:0] OpLdi  = 4'h1;
   localparam logic [3:0] OpLd   = 4'h2;
   localparam logic [3:0] OpSt   = 4'h3;
   localparam logic [3:0] OpAdd  = 4'h4;
   localparam logic [3:0] OpSub  = 4'h5;
   localparam logic [3:0] OpAnd  = 4'h6;
   localparam logic [3:0] OpOr   = 4'h7;
   localparam logic [3:0] OpXor  = 4'h8;
   localparam logic [3:0] OpShl  = 4'h9;
   localparam logic [3:0] OpJmp  = 4'hA;
   localparam logic [3:0] OpBeqz = 4'hB;
   localparam logic [3:0] OpHalt = 4'hF;

   localparam int unsigned OpLsb  = 12;
   localparam int unsigned RdLsb  = 8;
   localparam int unsigned RsLsb  = 4;
   localparam int unsigned ImmLsb = 0;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMemRd,
      StMemWait,
      StHalt
   } state_e;

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OpAdd) && (op <= OpShl);
   endfunction

   function automatic logic is_illegal_op(input logic [3:0] op);
      return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
   endfunction

endpackage

// File: rtl/tpu_seq_alu.sv
// Combinational ALU for tpu_seq: ADD/SUB/AND/OR/XOR/SHL with zero and carry/borrow flags.
module tpu_seq_alu
   import tpu_seq_pkg::*;
#(
   parameter int unsigned DW = 16
) (
   input  logic [3:0]    op_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] result_o,
   output logic          z_o,
   output logic          c_o,
   output logic          c_we_o
);

   always_comb begin
      result_o = a_i;
      c_o      = 1'b0;
      c_we_o   = 1'b0;
      case (op_i)
         OpAdd: begin
            {c_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
            c_we_o          = 1'b1;
         end
         // The extra top bit of the difference is the borrow.
         OpSub: begin
            {c_o, result_o} = {1'b0, a_i} - {1'b0, b_i};
            c_we_o          = 1'b1;
         end
         OpAnd: result_o = a_i & b_i;
         OpOr:  result_o = a_i | b_i;
         OpXor: result_o = a_i ^ b_i;
         OpShl: begin
            result_o = {a_i[DW-2:0], 1'b0};
            c_o      = a_i[DW-1];
            c_we_o   = 1'b1;
         end
         default: ;
      endcase
      z_o = (result_o == '0);
   end

endmodule

// File: rtl/tpu_seq.sv
// Instruction sequencer: ROM fetch handshake, decode, register file + ALU, RAM load/store.
// Define TPU_SEQ_TRACE_EN to add the o_TRACE_* instruction-retire trace port.
module tpu_seq
   import tpu_seq_pkg::*;
#(
   parameter int unsigned DW     = 16,
   parameter int unsigned NREG   = 8,
   parameter int unsigned PC_W   = 7,
   parameter int unsigned RAM_AW = 8
) (
   input  logic              i_SCLK,
   input  logic              i_RESET,
   input  logic              i_START,
   output logic              o_RD_RQST,
   output logic [PC_W-1:0]   o_ADDR,
   input  logic              i_ROM_READY,
   input  logic [15:0]       i_ROM_DATA,
   output logic              o_RAM_WEB,
   output logic              o_RAM_OEB,
   output logic [RAM_AW-1:0] o_RAM_ADDR,
   output logic [DW-1:0]     o_RAM_DATA,
   input  logic [DW-1:0]     i_RAM_DATA,
   output logic              o_BUSY,
   output logic              o_HALT,
   output logic              o_ILLEGAL
`ifdef TPU_SEQ_TRACE_EN
   ,
   output logic              o_TRACE_VALID,
   output logic [PC_W-1:0]   o_TRACE_PC,
   output logic [15:0]       o_TRACE_INST
`endif
);

   localparam int unsigned RW = $clog2(NREG);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q;
   logic [DW-1:0]     regs_q [NREG];
   logic              z_q, c_q;
   logic              web_q, oeb_q;
   logic [RAM_AW-1:0] ram_addr_q;
   logic [DW-1:0]     ram_data_q;

   logic [3:0]        op;
   logic [RW-1:0]     rd, rs;
   logic [7:0]        imm;
   logic [DW-1:0]     rd_val, rs_val;
   logic [PC_W-1:0]   jump_tgt;
   logic [DW-1:0]     alu_result;
   logic              alu_z, alu_c, alu_c_we;
   logic              unused_ir;

   assign op       = ir_q[OpLsb +: 4];
   assign rd       = ir_q[RdLsb +: RW];
   assign rs       = ir_q[RsLsb +: RW];
   assign imm      = ir_q[ImmLsb +: 8];
   assign rd_val   = regs_q[rd];
   assign rs_val   = regs_q[rs];
   assign jump_tgt = PC_W'(imm);
   // Register-select bits above RW are ignored by design.
   assign unused_ir = ^ir_q;

   tpu_seq_alu #(
      .DW (DW)
   ) u_alu (
      .op_i     (op),
      .a_i      (rd_val),
      .b_i      (rs_val),
      .result_o (alu_result),
      .z_o      (alu_z),
      .c_o      (alu_c),
      .c_we_o   (alu_c_we)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         StIdle, StHalt: begin
            if (i_START) begin
               state_d = StFetch;
               pc_d    = '0;
            end
         end
         StFetch:  if (i_ROM_READY) state_d = StDecode;
         StDecode: state_d = (op == OpLd) ? StMemRd : StExec;
         StExec: begin
            state_d = (op == OpHalt) ? StHalt : StFetch;
            pc_d    = pc_q + PC_W'(1);
            if ((op == OpJmp) || ((op == OpBeqz) && (rd_val == '0))) pc_d = jump_tgt;
         end
         StMemRd: state_d = StMemWait;
         StMemWait: begin
            state_d = StFetch;
            pc_d    = pc_q + PC_W'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_SCLK) begin
      if (i_RESET) begin
         state_q    <= StIdle;
         pc_q       <= '0;
         ir_q       <= '0;
         z_q        <= 1'b0;
         c_q        <= 1'b0;
         web_q      <= 1'b1;
         oeb_q      <= 1'b1;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         web_q   <= 1'b1;
         oeb_q   <= 1'b1;
         if ((state_q == StFetch) && i_ROM_READY) ir_q <= i_ROM_DATA;
         // Strobes are armed in DECODE so they land exactly on EXEC / MEM_RD.
         if ((state_q == StDecode) && ((op == OpSt) || (op == OpLd))) begin
            ram_addr_q <= RAM_AW'(imm);
            if (op == OpSt) begin
               web_q      <= 1'b0;
               ram_data_q <= rd_val;
            end else begin
               oeb_q <= 1'b0;
            end
         end
         if (state_q == StExec) begin
            if (op == OpLdi) regs_q[rd] <= DW'(imm);
            if (is_alu_op(op)) begin
               regs_q[rd] <= alu_result;
               z_q        <= alu_z;
               if (alu_c_we) c_q <= alu_c;
            end
         end
         if (state_q == StMemWait) regs_q[rd] <= i_RAM_DATA;
      end
   end

   assign o_RD_RQST  = (state_q == StFetch);
   assign o_ADDR     = pc_q;
   assign o_RAM_WEB  = web_q;
   assign o_RAM_OEB  = oeb_q;
   assign o_RAM_ADDR = ram_addr_q;
   assign o_RAM_DATA = ram_data_q;
   assign o_BUSY     = (state_q != StIdle) && (state_q != StHalt);
   assign o_HALT     = (state_q == StHalt);
   assign o_ILLEGAL  = (state_q == StExec) && is_illegal_op(op);

`ifdef TPU_SEQ_TRACE_EN
   assign o_TRACE_VALID = (state_q == StExec) || (state_q == StMemWait);
   assign o_TRACE_PC    = pc_q;
   assign o_TRACE_INST  = ir_q;
`endif

endmodule
